// File: rtl/ltc2308_ctrl_if.sv
// Host-side handshake between downstream logic and the LTC2308 controller.
// The master requests conversions; the slave (controller) returns results.
`timescale 1ns/1ps
interface ltc2308_ctrl_if;
    logic        start;
    logic [5:0]  cfg;
    logic        busy;
    logic        data_valid;
    logic [11:0] data;
    logic [5:0]  data_cfg;

    modport master (
        output start,
        output cfg,
        input  busy,
        input  data_valid,
        input  data,
        input  data_cfg
    );

    modport slave (
        input  start,
        input  cfg,
        output busy,
        output data_valid,
        output data,
        output data_cfg
    );
endinterface

// File: rtl/ltc2308_ctrl.sv
// LTC2308 SAR ADC controller: CONVST pulse, conversion wait, then one 12-bit
// SPI frame that shifts out the next config word while reading the result.
`timescale 1ns/1ps
module ltc2308_ctrl #(
    parameter int CONVST_CYCLES = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int CLK_DIV       = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    ltc2308_ctrl_if.slave  host,
    output logic           adc_convst,
    output logic           adc_sck,
    output logic           adc_sdi,
    input  logic           adc_sdo
);

    localparam int CNT_MAX_A = (CONVST_CYCLES > CONV_CYCLES) ? CONVST_CYCLES : CONV_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > CLK_DIV) ? CNT_MAX_A : CLK_DIV;
    localparam int CNT_W     = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        IDLE,
        CONV_HI,
        CONV_WAIT,
        SHIFT,
        DONE
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       bit_reg;
    logic [5:0]       cfg_q;
    logic [5:0]       prev_cfg_reg;
    logic [5:0]       sdi_sh_reg;
    logic [11:0]      shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            bit_reg         <= '0;
            cfg_q           <= '0;
            prev_cfg_reg    <= '0;
            sdi_sh_reg      <= '0;
            shreg           <= '0;
            adc_convst      <= 1'b0;
            adc_sck         <= 1'b0;
            adc_sdi         <= 1'b0;
            host.busy       <= 1'b0;
            host.data_valid <= 1'b0;
            host.data       <= '0;
            host.data_cfg   <= '0;
        end else begin
            host.data_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (host.start) begin
                        cfg_q      <= host.cfg;
                        cnt_reg    <= CNT_W'(CONVST_CYCLES - 1);
                        adc_convst <= 1'b1;
                        host.busy  <= 1'b1;
                        state_reg  <= CONV_HI;
                    end
                end

                CONV_HI: begin
                    if (cnt_reg == '0) begin
                        adc_convst <= 1'b0;
                        // MSB of the config word is presented before the first SCK edge.
                        adc_sdi    <= cfg_q[5];
                        sdi_sh_reg <= {cfg_q[4:0], 1'b0};
                        cnt_reg    <= CNT_W'(CONV_CYCLES - 1);
                        state_reg  <= CONV_WAIT;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                CONV_WAIT: begin
                    if (cnt_reg == '0) begin
                        cnt_reg   <= CNT_W'(CLK_DIV - 1);
                        bit_reg   <= '0;
                        state_reg <= SHIFT;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                SHIFT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        cnt_reg <= CNT_W'(CLK_DIV - 1);
                        if (!adc_sck) begin
                            // SDO was shifted by the ADC on the previous falling edge.
                            adc_sck <= 1'b1;
                            shreg   <= {shreg[10:0], adc_sdo};
                        end else begin
                            adc_sck <= 1'b0;
                            if (bit_reg == 4'd11) begin
                                adc_sdi         <= 1'b0;
                                host.data_valid <= 1'b1;
                                host.data       <= shreg;
                                host.data_cfg   <= prev_cfg_reg;
                                prev_cfg_reg    <= cfg_q;
                                state_reg       <= DONE;
                            end else begin
                                // Zeros fill in behind the six config bits.
                                bit_reg    <= bit_reg + 1'b1;
                                adc_sdi    <= sdi_sh_reg[5];
                                sdi_sh_reg <= {sdi_sh_reg[4:0], 1'b0};
                            end
                        end
                    end
                end

                DONE: begin
                    host.busy <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
